// File: rtl/jtframe_rstseq_pkg.sv
// Shared types and default timing constants for the PLL-lock reset sequencer.
package jtframe_rstseq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABLE     = 3'd1,
        SDRAM_INIT = 3'd2,
        RUN        = 3'd3,
        SOFT       = 3'd4
    } rstseq_state_t;

    localparam int LOCK_CYC_DEF  = 1024;
    localparam int SDRAM_DLY_DEF = 4096;
    localparam int SOFT_CYC_DEF  = 256;

endpackage

// File: rtl/jtframe_bitsync.sv
// Multi-flop synchronizer for a single asynchronous bit, with synchronous active-low clear.
module jtframe_bitsync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_ff <= '0;
        else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
    end

    assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/jtframe_lock_rstseq.sv
// Orders SDRAM and game resets after PLL lock, filters lock chatter,
// counts lock losses and services core-requested soft resets of the game.
module jtframe_lock_rstseq
    import jtframe_rstseq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CW          = 16,
    parameter int LOCK_CYC    = LOCK_CYC_DEF,
    parameter int SDRAM_DLY   = SDRAM_DLY_DEF,
    parameter int SOFT_CYC    = SOFT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       sdram_rst,
    output logic       game_rst,
    output logic       game_rst_n,
    output logic       lock_lost,
    output logic [7:0] lost_cnt
);

    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_CYC - 1);
    localparam logic [CW-1:0] SDRAM_LAST = CW'(SDRAM_DLY - 1);
    localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_CYC - 1);

    logic          lk_s;
    rstseq_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sdram_nx, game_nx, lost_nx;
    logic [7:0]    lost_cnt_nx;

    jtframe_bitsync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pll_locked),
        .q    (lk_s)
    );

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CW'(1);
        sdram_nx    = sdram_rst;
        game_nx     = game_rst;
        lost_nx     = 1'b0;
        lost_cnt_nx = lost_cnt;

        case (state)
            WAIT_LOCK: begin
                sdram_nx = 1'b1;
                game_nx  = 1'b1;
                cnt_nx   = '0;
                if (lk_s) state_nx = STABLE;
            end
            STABLE: begin
                sdram_nx = 1'b1;
                game_nx  = 1'b1;
                if (!lk_s) begin
                    // Lock chatter before SDRAM release is filtered, not counted
                    state_nx = WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nx = SDRAM_INIT;
                    cnt_nx   = '0;
                    sdram_nx = 1'b0;
                end
            end
            SDRAM_INIT: begin
                sdram_nx = 1'b0;
                game_nx  = 1'b1;
                if (cnt == SDRAM_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    game_nx  = 1'b0;
                end
            end
            RUN: begin
                sdram_nx = 1'b0;
                game_nx  = 1'b0;
                cnt_nx   = '0;
                if (soft_rst) begin
                    state_nx = SOFT;
                    game_nx  = 1'b1;
                end
            end
            SOFT: begin
                sdram_nx = 1'b0;
                game_nx  = 1'b1;
                if (cnt == SOFT_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    game_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = WAIT_LOCK;
                cnt_nx   = '0;
                sdram_nx = 1'b1;
                game_nx  = 1'b1;
            end
        endcase

        // A lock loss once SDRAM is out of reset overrides every other event
        if ((state == SDRAM_INIT || state == RUN || state == SOFT) && !lk_s) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
            sdram_nx = 1'b1;
            game_nx  = 1'b1;
            lost_nx  = 1'b1;
            if (lost_cnt != 8'hFF) lost_cnt_nx = lost_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            sdram_rst  <= 1'b1;
            game_rst   <= 1'b1;
            game_rst_n <= 1'b0;
            lock_lost  <= 1'b0;
            lost_cnt   <= 8'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sdram_rst  <= sdram_nx;
            game_rst   <= game_nx;
            game_rst_n <= ~game_nx;
            lock_lost  <= lost_nx;
            lost_cnt   <= lost_cnt_nx;
        end
    end

endmodule

// File: tb/tb_jtframe_lock_rstseq.sv
// Directed bench for the PLL-lock reset sequencer (SYNC_STAGES=2, LOCK_CYC=8, SDRAM_DLY=16, SOFT_CYC=4).
module tb_jtframe_lock_rstseq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       soft_rst;
    logic       sdram_rst;
    logic       game_rst;
    logic       game_rst_n;
    logic       lock_lost;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    jtframe_lock_rstseq #(
        .SYNC_STAGES(2),
        .CW         (16),
        .LOCK_CYC   (8),
        .SDRAM_DLY  (16),
        .SOFT_CYC   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .soft_rst  (soft_rst),
        .sdram_rst (sdram_rst),
        .game_rst  (game_rst),
        .game_rst_n(game_rst_n),
        .lock_lost (lock_lost),
        .lost_cnt  (lost_cnt)
    );

    always #5 clk = ~clk;

    // Ordering invariant and lock_lost pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if (lock_lost === 1'b1) pulses++;
        checks++;
        if (game_rst === 1'b0 && sdram_rst !== 1'b0) begin
            errors++;
            $display("FAIL order_invariant: game_rst=%b sdram_rst=%b required sdram_rst=0", game_rst, sdram_rst);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b0; soft_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({sdram_rst, game_rst, game_rst_n, lock_lost} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 1100", {sdram_rst, game_rst, game_rst_n, lock_lost});
        end
        checks++;
        if (lost_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_lost_cnt: got %0d required 0", lost_cnt);
        end
    endtask

    task automatic test_powerup();
        rst_n = 1'b1; pll_locked = 1'b1;        // next edge is p
        repeat (10) tick();                     // through p+9
        checks++;
        if (sdram_rst !== 1'b1) begin
            errors++; $display("FAIL pwr_sdram_hold: got %b required 1 at p+9", sdram_rst);
        end
        tick();                                 // p+10
        checks++;
        if (sdram_rst !== 1'b0 || game_rst !== 1'b1) begin
            errors++; $display("FAIL pwr_sdram_release: sdram=%b game=%b required 0/1 at p+10", sdram_rst, game_rst);
        end
        repeat (15) tick();                     // p+25
        checks++;
        if (game_rst !== 1'b1) begin
            errors++; $display("FAIL pwr_game_hold: got %b required 1 at p+25", game_rst);
        end
        tick();                                 // p+26
        checks++;
        if (game_rst !== 1'b0 || game_rst_n !== 1'b1) begin
            errors++; $display("FAIL pwr_game_release: game=%b game_n=%b required 0/1 at p+26", game_rst, game_rst_n);
        end
        checks++;
        if (lost_cnt !== 8'd0 || pulses !== 0) begin
            errors++; $display("FAIL pwr_no_loss: lost_cnt=%0d pulses=%0d required 0/0", lost_cnt, pulses);
        end
    endtask

    task automatic test_glitch();
        int p0;
        rst_n = 1'b0; pll_locked = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        p0 = pulses;
        pll_locked = 1'b1; repeat (5) tick();
        pll_locked = 1'b0; repeat (3) tick();
        pll_locked = 1'b1;                      // final rise sampled at next edge p
        repeat (10) tick();
        checks++;
        if (sdram_rst !== 1'b1) begin
            errors++; $display("FAIL glitch_hold: sdram=%b required 1 at p+9", sdram_rst);
        end
        tick();
        checks++;
        if (sdram_rst !== 1'b0) begin
            errors++; $display("FAIL glitch_release: sdram=%b required 0 at p+10", sdram_rst);
        end
        checks++;
        if (lost_cnt !== 8'd0 || pulses !== p0) begin
            errors++; $display("FAIL glitch_not_counted: lost_cnt=%0d pulses=%0d required 0/%0d", lost_cnt, pulses, p0);
        end
        repeat (16) tick();
        checks++;
        if (game_rst !== 1'b0) begin
            errors++; $display("FAIL glitch_run: game=%b required 0", game_rst);
        end
    endtask

    task automatic test_loss_run();
        int p0;
        p0 = pulses;
        pll_locked = 1'b0;
        repeat (2) tick();                      // d, d+1
        checks++;
        if (sdram_rst !== 1'b0 || game_rst !== 1'b0) begin
            errors++; $display("FAIL loss_early: sdram=%b game=%b required 0/0 at d+1", sdram_rst, game_rst);
        end
        tick();                                 // d+2
        checks++;
        if ({sdram_rst, game_rst, lock_lost} !== 3'b111 || lost_cnt !== 8'd1) begin
            errors++; $display("FAIL loss_detect: rst/rst/lost=%b lost_cnt=%0d required 111/1", {sdram_rst, game_rst, lock_lost}, lost_cnt);
        end
        tick();                                 // d+3
        checks++;
        if (lock_lost !== 1'b0 || pulses - p0 !== 1) begin
            errors++; $display("FAIL loss_pulse_width: lock_lost=%b pulses=%0d required 0/1", lock_lost, pulses - p0);
        end
        pll_locked = 1'b1;                      // edge p = d+4
        repeat (10) tick();
        checks++;
        if (sdram_rst !== 1'b1) begin
            errors++; $display("FAIL relock_hold: sdram=%b required 1", sdram_rst);
        end
        tick();
        checks++;
        if (sdram_rst !== 1'b0) begin
            errors++; $display("FAIL relock_sdram: sdram=%b required 0", sdram_rst);
        end
        repeat (16) tick();
        checks++;
        if (game_rst !== 1'b0 || lost_cnt !== 8'd1) begin
            errors++; $display("FAIL relock_game: game=%b lost_cnt=%0d required 0/1", game_rst, lost_cnt);
        end
    endtask

    task automatic test_soft();
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (game_rst !== 1'b1 || sdram_rst !== 1'b0) begin
                errors++; $display("FAIL soft_pulse_%0d: game=%b sdram=%b required 1/0", i, game_rst, sdram_rst);
            end
            tick();
        end
        checks++;
        if (game_rst !== 1'b0 || game_rst_n !== 1'b1) begin
            errors++; $display("FAIL soft_end: game=%b game_n=%b required 0/1", game_rst, game_rst_n);
        end
        // soft request while SDRAM is still initialising
        rst_n = 1'b0; tick(); rst_n = 1'b1;     // next edge is p
        repeat (12) tick();                     // p+11, in SDRAM_INIT
        soft_rst = 1'b1; tick(); soft_rst = 1'b0; // p+12
        repeat (13) tick();                     // p+25
        checks++;
        if (game_rst !== 1'b1) begin
            errors++; $display("FAIL soft_in_init_hold: game=%b required 1 at p+25", game_rst);
        end
        tick();
        checks++;
        if (game_rst !== 1'b0) begin
            errors++; $display("FAIL soft_in_init_release: game=%b required 0 at p+26", game_rst);
        end
        tick();
        checks++;
        if (game_rst !== 1'b0) begin
            errors++; $display("FAIL soft_in_init_ignored: game=%b required 0 at p+27", game_rst);
        end
    endtask

    task automatic test_simultaneous();
        pll_locked = 1'b0;
        repeat (2) tick();
        soft_rst = 1'b1;                        // coincides with lk_s=0 seen by FSM
        tick();
        soft_rst = 1'b0;
        checks++;
        if ({sdram_rst, game_rst, lock_lost} !== 3'b111 || lost_cnt !== 8'd1) begin
            errors++; $display("FAIL simul_loss_wins: rst/rst/lost=%b lost_cnt=%0d required 111/1", {sdram_rst, game_rst, lock_lost}, lost_cnt);
        end
        tick();
        checks++;
        if (sdram_rst !== 1'b1) begin
            errors++; $display("FAIL simul_no_soft: sdram=%b required 1", sdram_rst);
        end
    endtask

    task automatic test_saturation();
        int p0;
        int exp_cnt;
        p0 = pulses;
        exp_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            repeat (12) tick();
            pll_locked = 1'b0;
            repeat (3) tick();
            exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
            checks++;
            if (lock_lost !== 1'b1 || lost_cnt !== exp_cnt[7:0]) begin
                errors++; $display("FAIL sat_loss_%0d: lock_lost=%b lost_cnt=%0d required 1/%0d", i, lock_lost, lost_cnt, exp_cnt);
            end
            tick();
        end
        checks++;
        if (pulses - p0 !== 300) begin
            errors++; $display("FAIL sat_pulse_count: got %0d required 300", pulses - p0);
        end
        pll_locked = 1'b1;
        repeat (12) tick();                     // SDRAM_INIT
        checks++;
        if (sdram_rst !== 1'b0 || game_rst !== 1'b1) begin
            errors++; $display("FAIL midseq_setup: sdram=%b game=%b required 0/1", sdram_rst, game_rst);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({sdram_rst, game_rst, game_rst_n, lock_lost} !== 4'b1100 || lost_cnt !== 8'd0) begin
            errors++; $display("FAIL midseq_reset: outs=%b lost_cnt=%0d required 1100/0", {sdram_rst, game_rst, game_rst_n, lock_lost}, lost_cnt);
        end
        rst_n = 1'b1;
        pll_locked = 1'b0;
        repeat (3) tick();
        checks++;
        if (sdram_rst !== 1'b1 || game_rst !== 1'b1 || lost_cnt !== 8'd0) begin
            errors++; $display("FAIL midseq_after: sdram=%b game=%b lost_cnt=%0d required 1/1/0", sdram_rst, game_rst, lost_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_glitch();
        test_loss_run();
        test_soft();
        test_simultaneous();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
